// File: rtl/register_file_bist_ctrl.sv
// March C- BIST initiator for the register-file test port.
// Walks every word through six march elements, compares each read against
// the expected background and reports pass/fail, first failing address and
// a saturating miscompare count.
module register_file_bist_ctrl #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_WORDS = 2**ADDR_WIDTH,
   parameter int READ_LATENCY = 1,
   parameter logic [DATA_WIDTH-1:0] BACKGROUND = DATA_WIDTH'({DATA_WIDTH{2'b01}}),
   parameter int CNT_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic                  abort_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  fail_o,
   output logic [ADDR_WIDTH-1:0] fail_addr_o,
   output logic [CNT_WIDTH-1:0]  fail_cnt_o,
   output logic                  BIST,
   output logic                  CSN_T,
   output logic                  WEN_T,
   output logic [ADDR_WIDTH-1:0] A_T,
   output logic [DATA_WIDTH-1:0] D_T,
   input  logic [DATA_WIDTH-1:0] Q_T
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);

   state_t state, state_n;

   // Cursor pointing at the next op to issue: element, address, op-within-address
   logic [2:0]            elem, elem_adv, op_elem;
   logic [ADDR_WIDTH-1:0] addr, addr_adv, op_addr;
   logic                  sub, sub_adv, op_sub;

   logic single, is_read, exp_one, wr_one, descending, at_end, last_op;

   logic                  bist_n, csn_n, wen_n, busy_n, done_n;
   logic [ADDR_WIDTH-1:0] a_n;
   logic [DATA_WIDTH-1:0] d_n;
   logic                  push, flush, cmp_en, clear_fail, advance, drain_empty, miscompare;

   // Stage 0 tracks the read currently on the bus; stage READ_LATENCY is the
   // one whose data is present on Q_T at the current edge.
   logic [READ_LATENCY:0] pipe_valid;
   logic [READ_LATENCY:0] pipe_exp;
   logic [ADDR_WIDTH-1:0] pipe_addr [READ_LATENCY+1];

   // Decode the op at the cursor and work out where the cursor goes after it
   always_comb begin
      op_elem = elem;
      op_addr = addr;
      op_sub  = sub;
      if (state == IDLE || state == DONE) begin
         op_elem = '0;
         op_addr = '0;
         op_sub  = 1'b0;
      end
      single     = (op_elem == 3'd0) || (op_elem == 3'd5);
      is_read    = (op_elem == 3'd5) || ((op_elem != 3'd0) && !op_sub);
      exp_one    = (op_elem == 3'd2) || (op_elem == 3'd4);
      wr_one     = (op_elem == 3'd1) || (op_elem == 3'd3);
      descending = (op_elem >= 3'd3);
      at_end     = descending ? (op_addr == '0) : (op_addr == LAST_ADDR);
      last_op    = (op_elem == 3'd5) && at_end;
      elem_adv   = op_elem;
      addr_adv   = op_addr;
      sub_adv    = 1'b0;
      if (!single && !op_sub) begin
         sub_adv = 1'b1;
      end else if (at_end) begin
         elem_adv = op_elem + 3'd1;
         addr_adv = (op_elem >= 3'd2) ? LAST_ADDR : '0;
      end else if (descending) begin
         addr_adv = op_addr - ADDR_WIDTH'(1);
      end else begin
         addr_adv = op_addr + ADDR_WIDTH'(1);
      end
   end

   assign drain_empty = (pipe_valid[READ_LATENCY-1:0] == '0);
   assign miscompare  = cmp_en && pipe_valid[READ_LATENCY] &&
                        (Q_T != (pipe_exp[READ_LATENCY] ? ~BACKGROUND : BACKGROUND));

   // Next-state and next-output logic; outputs hold unless an op is issued
   always_comb begin
      state_n    = state;
      bist_n     = BIST;
      csn_n      = 1'b1;
      wen_n      = 1'b1;
      a_n        = A_T;
      d_n        = D_T;
      busy_n     = busy_o;
      done_n     = done_o;
      push       = 1'b0;
      flush      = 1'b0;
      cmp_en     = 1'b0;
      clear_fail = 1'b0;
      advance    = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start_i) begin
               state_n    = RUN;
               busy_n     = 1'b1;
               done_n     = 1'b0;
               bist_n     = 1'b1;
               clear_fail = 1'b1;
               advance    = 1'b1;
            end
         end
         RUN: begin
            if (abort_i) begin
               state_n = IDLE;
               flush   = 1'b1;
               bist_n  = 1'b0;
               busy_n  = 1'b0;
               done_n  = 1'b0;
            end else begin
               cmp_en  = 1'b1;
               advance = 1'b1;
               if (last_op) state_n = DRAIN;
            end
         end
         DRAIN: begin
            if (abort_i) begin
               state_n = IDLE;
               flush   = 1'b1;
               bist_n  = 1'b0;
               busy_n  = 1'b0;
               done_n  = 1'b0;
            end else begin
               cmp_en = 1'b1;
               if (drain_empty) begin
                  state_n = DONE;
                  busy_n  = 1'b0;
                  done_n  = 1'b1;
                  bist_n  = 1'b0;
               end
            end
         end
         default: state_n = IDLE;
      endcase
      if (advance) begin
         csn_n = 1'b0;
         wen_n = is_read;
         a_n   = op_addr;
         push  = is_read;
         if (!is_read) d_n = wr_one ? ~BACKGROUND : BACKGROUND;
      end
   end

   // FSM state and march cursor
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         elem  <= '0;
         addr  <= '0;
         sub   <= 1'b0;
      end else begin
         state <= state_n;
         if (advance) begin
            elem <= elem_adv;
            addr <= addr_adv;
            sub  <= sub_adv;
         end
      end
   end

   // Registered test-port and status outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         BIST   <= 1'b0;
         CSN_T  <= 1'b1;
         WEN_T  <= 1'b1;
         A_T    <= '0;
         D_T    <= '0;
         busy_o <= 1'b0;
         done_o <= 1'b0;
      end else begin
         BIST   <= bist_n;
         CSN_T  <= csn_n;
         WEN_T  <= wen_n;
         A_T    <= a_n;
         D_T    <= d_n;
         busy_o <= busy_n;
         done_o <= done_n;
      end
   end

   // Read-compare pipeline and sticky fail status
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe_valid  <= '0;
         pipe_exp    <= '0;
         for (int i = 0; i <= READ_LATENCY; i++) pipe_addr[i] <= '0;
         fail_o      <= 1'b0;
         fail_addr_o <= '0;
         fail_cnt_o  <= '0;
      end else begin
         if (flush) begin
            pipe_valid <= '0;
         end else begin
            pipe_valid <= {pipe_valid[READ_LATENCY-1:0], push};
         end
         pipe_exp     <= {pipe_exp[READ_LATENCY-1:0], exp_one};
         pipe_addr[0] <= op_addr;
         for (int i = 1; i <= READ_LATENCY; i++) pipe_addr[i] <= pipe_addr[i-1];
         if (clear_fail) begin
            fail_o      <= 1'b0;
            fail_addr_o <= '0;
            fail_cnt_o  <= '0;
         end else if (miscompare) begin
            fail_o <= 1'b1;
            if (!fail_o) fail_addr_o <= pipe_addr[READ_LATENCY];
            if (fail_cnt_o != {CNT_WIDTH{1'b1}}) fail_cnt_o <= fail_cnt_o + CNT_WIDTH'(1);
         end
      end
   end

endmodule
